// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
//   rxState_e   : receiver FSM states
//   majority3   : 2-of-3 vote used to de-glitch the sampled line
//   paramsLegal : elaboration-time parameter sanity check
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StHold
  } rxState_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic bit paramsLegal(input int unsigned dataBits,
                                     input int unsigned oversample,
                                     input int unsigned validHold,
                                     input int unsigned parityOdd);
    return (dataBits >= 5) && (dataBits <= 9) &&
           (oversample >= 4) && ((oversample % 2) == 0) &&
           (validHold >= 1) && (validHold <= oversample / 2) &&
           (parityOdd <= 1);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver.
// Ports:
//   clk    in  oversample clock
//   rst    in  synchronous reset, active-low
//   rx     in  asynchronous serial line (idle high)
//   abort  in  asynchronous abort request
//   rxS    out rx after a 2-flop synchroniser
//   abS    out abort after a 2-flop synchroniser
//   maj    out majority of the last three rxS samples
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic abort,
  output logic rxS,
  output logic abS,
  output logic maj
);

  logic       rxMeta;
  logic       abMeta;
  logic [2:0] hist;

  // Line reset value is the idle level so no spurious low is seen after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      abMeta <= 1'b0;
      abS    <= 1'b0;
      hist   <= 3'b111;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
      abMeta <= abort;
      abS    <= abMeta;
      hist   <= {hist[1:0], rxS};
    end
  end

  assign maj = majority3(hist);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-voted, LSB-first, 1 stop bit,
// back-to-back frames, framing-error flag, optional parity (macro UART_RX_PARITY_EN).
// Ports:
//   clk        in  oversample clock (OVERSAMPLE cycles per bit)
//   rst        in  synchronous reset, active-low
//   abort      in  async; high drops the frame in progress
//   rx         in  async serial line, idle high
//   oValid     out frame complete, high for VALID_HOLD cycles
//   oData      out received word, held until the next frame completes
//   oFrameErr  out stop bit sampled low (qualifies oValid)
//   oBusy      out receiving a frame (DATA/PARITY/STOP)
//   oParityErr out parity mismatch (only with UART_RX_PARITY_EN)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned VALID_HOLD = 3,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 rx,
  output logic                 oValid,
  output logic [DATA_BITS-1:0] oData,
  output logic                 oFrameErr,
  output logic                 oBusy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 oParityErr
`endif
);

  if (!paramsLegal(DATA_BITS, OVERSAMPLE, VALID_HOLD, PARITY_ODD)) begin : gBadParams
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int unsigned CntW  = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_BITS + 1);
  localparam int unsigned HoldW = $clog2(VALID_HOLD + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0]  LowLast  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_BITS - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(VALID_HOLD - 1);

  logic rxS;
  logic abS;
  logic maj;

  uart_rx_sampler uSampler (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .abort(abort),
    .rxS  (rxS),
    .abS  (abS),
    .maj  (maj)
  );

  rxState_e             stateQ,    stateD;
  logic [CntW-1:0]      cntQ,      cntD;
  logic [CntW-1:0]      lowCntQ,   lowCntD;
  logic [IdxW-1:0]      bitIdxQ,   bitIdxD;
  logic [HoldW-1:0]     holdCntQ,  holdCntD;
  logic [DATA_BITS-1:0] wordQ,     wordD;
  logic                 armedQ,    armedD;
  logic                 validQ,    validD;
  logic [DATA_BITS-1:0] dataQ,     dataD;
  logic                 frameErrQ, frameErrD;
  logic                 startHit;
`ifdef UART_RX_PARITY_EN
  localparam logic OddSense = (PARITY_ODD != 0);
  logic parityBitQ, parityBitD;
  logic parityErrQ, parityErrD;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ     <= StIdle;
      cntQ       <= '0;
      lowCntQ    <= '0;
      bitIdxQ    <= '0;
      holdCntQ   <= '0;
      wordQ      <= '0;
      armedQ     <= 1'b0;
      validQ     <= 1'b0;
      dataQ      <= '0;
      frameErrQ  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBitQ <= 1'b0;
      parityErrQ <= 1'b0;
`endif
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      lowCntQ    <= lowCntD;
      bitIdxQ    <= bitIdxD;
      holdCntQ   <= holdCntD;
      wordQ      <= wordD;
      armedQ     <= armedD;
      validQ     <= validD;
      dataQ      <= dataD;
      frameErrQ  <= frameErrD;
`ifdef UART_RX_PARITY_EN
      parityBitQ <= parityBitD;
      parityErrQ <= parityErrD;
`endif
    end
  end

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    lowCntD    = lowCntQ;
    bitIdxD    = bitIdxQ;
    holdCntD   = holdCntQ;
    wordD      = wordQ;
    armedD     = armedQ;
    validD     = validQ;
    dataD      = dataQ;
    frameErrD  = frameErrQ;
    startHit   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBitD = parityBitQ;
    parityErrD = parityErrQ;
`endif

    // Start detection runs in IDLE and HOLD so a start bit directly after a
    // 1-stop-bit frame is caught. Arming only here (never mid-frame) keeps a
    // break after a framing error from being taken as a new start.
    if ((stateQ == StIdle) || (stateQ == StHold)) begin
      if (rxS) begin
        armedD  = 1'b1;
        lowCntD = '0;
      end else if (armedQ && !abS) begin
        if (lowCntQ == LowLast) begin
          startHit = 1'b1;
        end else begin
          lowCntD = lowCntQ + 1'b1;
        end
      end else begin
        lowCntD = '0;
      end
    end

    if (startHit) begin
      stateD   = StData;
      cntD     = '0;
      bitIdxD  = '0;
      wordD    = '0;
      armedD   = 1'b0;
      lowCntD  = '0;
      holdCntD = '0;
      validD   = 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: ;

        StData: begin
          if (abS) begin
            stateD  = StIdle;
            cntD    = '0;
            bitIdxD = '0;
          end else if (cntQ == CntLast) begin
            cntD    = '0;
            wordD   = {maj, wordQ[DATA_BITS-1:1]};
            bitIdxD = bitIdxQ + 1'b1;
            if (bitIdxQ == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              stateD = StParity;
`else
              stateD = StStop;
`endif
            end
          end else begin
            cntD = cntQ + 1'b1;
          end
        end

        StParity: begin
          if (abS) begin
            stateD  = StIdle;
            cntD    = '0;
            bitIdxD = '0;
          end else if (cntQ == CntLast) begin
            cntD   = '0;
            stateD = StStop;
`ifdef UART_RX_PARITY_EN
            parityBitD = maj;
`endif
          end else begin
            cntD = cntQ + 1'b1;
          end
        end

        StStop: begin
          // Abort is checked first so it wins over a coincident stop centre.
          if (abS) begin
            stateD  = StIdle;
            cntD    = '0;
            bitIdxD = '0;
          end else if (cntQ == CntLast) begin
            cntD      = '0;
            bitIdxD   = '0;
            holdCntD  = '0;
            validD    = 1'b1;
            dataD     = wordQ;
            frameErrD = ~maj;
`ifdef UART_RX_PARITY_EN
            parityErrD = ((^wordQ) ^ parityBitQ) != OddSense;
`endif
            stateD    = StHold;
          end else begin
            cntD = cntQ + 1'b1;
          end
        end

        StHold: begin
          if (holdCntQ == HoldLast) begin
            validD   = 1'b0;
            holdCntD = '0;
            stateD   = StIdle;
          end else begin
            holdCntD = holdCntQ + 1'b1;
          end
        end

        default: begin
          stateD = StIdle;
          cntD   = '0;
          validD = 1'b0;
        end
      endcase
    end
  end

  assign oValid    = validQ;
  assign oData     = dataQ;
  assign oFrameErr = frameErrQ;
  assign oBusy     = (stateQ == StData) || (stateQ == StParity) || (stateQ == StStop);
`ifdef UART_RX_PARITY_EN
  assign oParityErr = parityErrQ;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned DB = 7;
  localparam int unsigned PB = 1;
`else
  localparam int unsigned DB = 8;
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned OS   = 16;
  localparam int unsigned VH   = 3;
  localparam int unsigned PODD = 0;
  // Falling edge of start bit to stop-bit centre, in clk cycles.
  localparam int unsigned BASE = (DB + PB + 1) * OS + OS / 2;
  localparam int unsigned MASK = (1 << DB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          abort = 1'b0;
  logic          rx = 1'b1;
  logic          oValid;
  logic [DB-1:0] oData;
  logic          oFrameErr;
  logic          oBusy;
  logic          oParityErr;

  uart_rx_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .VALID_HOLD(VH),
    .PARITY_ODD(PODD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .rx       (rx),
    .oValid   (oValid),
    .oData    (oData),
    .oFrameErr(oFrameErr),
    .oBusy    (oBusy)
`ifdef UART_RX_PARITY_EN
    ,
    .oParityErr(oParityErr)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign oParityErr = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned data;
    bit          ferr;
    bit          perr;
    int unsigned t;
    int unsigned width;
  } frame_t;

  frame_t expQ[$];
  frame_t gotQ[$];

  int checks = 0;
  int errors = 0;

  // Monitor: one record per oValid pulse, pushed when the pulse ends.
  frame_t      cur;
  bit          inPulse = 1'b0;
  int unsigned busyCycles = 0;
  always @(negedge clk) begin
    if (oBusy) busyCycles++;
    if (oValid && !inPulse) begin
      inPulse   = 1'b1;
      cur.data  = int'(oData);
      cur.ferr  = oFrameErr;
      cur.perr  = oParityErr;
      cur.t     = cyc;
      cur.width = 1;
    end else if (oValid) begin
      cur.width++;
    end else if (inPulse) begin
      inPulse = 1'b0;
      gotQ.push_back(cur);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkRange(input string tag, input int unsigned got,
                          input int unsigned lo, input int unsigned hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic idleBits(input int unsigned n);
    rx = 1'b1;
    repeat (n * OS) @(negedge clk);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (OS) @(negedge clk);
  endtask

  // Serialise one frame starting at a negedge; record the expected result.
  task automatic sendFrame(input int unsigned data, input bit stopBit, input bit parFlip,
                           input int abortAt, input bit want);
    frame_t      e;
    int unsigned ones;
    bit          pbit;
    e.data  = data & MASK;
    e.t     = cyc;
    e.width = VH;
    e.ferr  = !stopBit;
    ones    = $countones(e.data);
    pbit    = (((ones + PODD) % 2) != 0) ^ parFlip;
    e.perr  = (PB != 0) && (((ones + pbit) % 2) != PODD);
    driveBit(1'b0);
    for (int i = 0; i < int'(DB); i++) begin
      if (i == abortAt) begin
        rx = e.data[i];
        repeat (OS / 2) @(negedge clk);
        abort = 1'b1;
        repeat (OS - OS / 2) @(negedge clk);
      end else begin
        driveBit(e.data[i]);
      end
    end
    if (PB != 0) driveBit(pbit);
    driveBit(stopBit);
    abort = 1'b0;
    if (want) expQ.push_back(e);
  endtask

  task automatic checkFrames(input string tag);
    frame_t g;
    frame_t e;
    chk({tag, " count"}, gotQ.size(), expQ.size());
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      e = expQ.pop_front();
      chk({tag, " data"}, g.data, e.data);
      chk({tag, " ferr"}, g.ferr, e.ferr);
      chk({tag, " perr"}, g.perr, e.perr);
      chk({tag, " width"}, g.width, e.width);
      chkRange({tag, " latency"}, g.t - e.t, BASE + 1, BASE + 4);
    end
    gotQ.delete();
    expQ.delete();
  endtask

  int unsigned b0;
  int unsigned rdata;
  bit          rerr;
  bit          rflip;

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    chk("reset oValid", oValid, 0);
    chk("reset oData", oData, 0);
    chk("reset oFrameErr", oFrameErr, 0);
    chk("reset oBusy", oBusy, 0);
    chk("reset oParityErr", oParityErr, 0);
    rst = 1'b1;
    idleBits(3);

    // 1: single clean frame
    sendFrame(32'hA5, 1'b1, 1'b0, -1, 1'b1);
    idleBits(2);
    checkFrames("t1");

    // 2: 7-cycle glitch is not a start bit
    b0 = busyCycles;
    rx = 1'b0;
    repeat (7) @(negedge clk);
    idleBits(3);
    chk("t2 busy", busyCycles - b0, 0);
    checkFrames("t2");

    // 3: framing error followed by a long break, then a clean frame
    sendFrame(32'h3C, 1'b0, 1'b0, -1, 1'b1);
    rx = 1'b0;
    repeat (40 * OS) @(negedge clk);
    idleBits(2);
    sendFrame(32'h81, 1'b1, 1'b0, -1, 1'b1);
    idleBits(2);
    checkFrames("t3");

    // 4: abort during data bit 4, next frame intact
    sendFrame(32'h55, 1'b1, 1'b0, 4, 1'b0);
    idleBits(2);
    sendFrame(32'h0F, 1'b1, 1'b0, -1, 1'b1);
    idleBits(2);
    checkFrames("t4");

    // 5: back-to-back frames, one stop bit
    sendFrame(32'h11, 1'b1, 1'b0, -1, 1'b1);
    sendFrame(32'h22, 1'b1, 1'b0, -1, 1'b1);
    sendFrame(32'h33, 1'b1, 1'b0, -1, 1'b1);
    idleBits(2);
    checkFrames("t5");

    // 6: correct and flipped parity bit (plain frames without parity)
    sendFrame(32'h41, 1'b1, 1'b0, -1, 1'b1);
    idleBits(1);
    sendFrame(32'h41, 1'b1, 1'b1, -1, 1'b1);
    idleBits(2);
    checkFrames("t6");

    // Mid-frame reset drops the frame and clears outputs
    rx = 1'b0;
    repeat (3 * OS) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst oBusy", oBusy, 0);
    chk("midrst oData", oData, 0);
    chk("midrst oValid", oValid, 0);
    rx  = 1'b1;
    rst = 1'b1;
    idleBits(3);
    checkFrames("midrst");

    // Random traffic
    for (int n = 0; n < 16; n++) begin
      rdata = $urandom & MASK;
      rerr  = ($urandom_range(0, 5) == 0);
      rflip = ($urandom_range(0, 3) == 0);
      sendFrame(rdata, !rerr, rflip, -1, 1'b1);
      if (rerr) idleBits(1 + $urandom_range(0, 1));
      else idleBits($urandom_range(0, 2));
    end
    idleBits(2);
    checkFrames("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
